// File: rtl/fp_pkg.sv
// Shared constants and payload types for the single-precision add front end
// (fp_unpack, fp_align_add).
package fp_pkg;

  localparam int EXP_W    = 8;
  localparam int FRAC_W   = 23;
  localparam int EXP_BIAS = 127;
  localparam int SIG_W    = FRAC_W + 1;

  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] eff_exp;
    logic [SIG_W-1:0] sig;
  } operand_t;

  typedef struct packed {
    logic [SIG_W-1:0] sig_l;
    logic [SIG_W-1:0] sig_s;
    logic [EXP_W-1:0] exp_max;
    logic             sign;
    logic             eff_sub;
  } stage1_t;

endpackage

// File: rtl/fp_unpack.sv
// Combinational IEEE754 single-precision field split. Denormals (exp field 0)
// get an effective exponent of 1 and no hidden bit.
module fp_unpack
  import fp_pkg::*;
(
  input  logic [EXP_W+FRAC_W:0] word,
  output logic                  sign,
  output logic [EXP_W-1:0]      eff_exp,
  output logic [SIG_W-1:0]      sig
);

  logic [EXP_W-1:0] exp_field;
  logic             hidden;

  assign exp_field = word[EXP_W+FRAC_W-1:FRAC_W];
  assign hidden    = |exp_field;
  assign sign      = word[EXP_W+FRAC_W];
  assign eff_exp   = hidden ? exp_field : EXP_W'(1);
  assign sig       = {hidden, word[FRAC_W-1:0]};

endmodule

// File: rtl/fp_align_add.sv
// Two-stage align and add/sub front end of the single-precision adder.
// Optional macro FP_ALIGN_ADD_SUB_OP_EN adds op_sub (computes A - B when 1).
module fp_align_add
  import fp_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
`ifdef FP_ALIGN_ADD_SUB_OP_EN
  input  logic                  op_sub,
`endif
  input  logic [EXP_W+FRAC_W:0] in_a,
  input  logic [EXP_W+FRAC_W:0] in_b,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_sign,
  output logic [EXP_W-1:0]      out_exp_max,
  output logic [SIG_W:0]        out_fraction_25,
  output logic                  out_eff_sub
);

  localparam logic [EXP_W-1:0] BIAS_V = EXP_W'(EXP_BIAS);

  // Right shift with plain truncation; shifts past the significand width give zero.
  function automatic logic [SIG_W-1:0] align_shift(input logic [SIG_W-1:0] sig,
                                                   input logic [EXP_W-1:0] sh);
    if (sh >= EXP_W'(SIG_W))
      return '0;
    return sig >> sh;
  endfunction

  logic             sign_a, sign_b_raw, sign_b;
  logic [EXP_W-1:0] exp_a, exp_b;
  logic [SIG_W-1:0] sig_a, sig_b;

  fp_unpack u_unpack_a (.word(in_a), .sign(sign_a), .eff_exp(exp_a), .sig(sig_a));
  fp_unpack u_unpack_b (.word(in_b), .sign(sign_b_raw), .eff_exp(exp_b), .sig(sig_b));

`ifdef FP_ALIGN_ADD_SUB_OP_EN
  assign sign_b = sign_b_raw ^ op_sub;
`else
  assign sign_b = sign_b_raw;
`endif

  operand_t         op_a, op_b, op_l, op_s;
  logic             a_wins;
  logic [EXP_W-1:0] diff;
  stage1_t          s1_next;

  assign op_a   = {sign_a, exp_a, sig_a};
  assign op_b   = {sign_b, exp_b, sig_b};
  // Magnitude order on {exponent, significand}; ties keep A as the larger.
  assign a_wins = {exp_a, sig_a} >= {exp_b, sig_b};
  assign op_l   = a_wins ? op_a : op_b;
  assign op_s   = a_wins ? op_b : op_a;
  assign diff   = op_l.eff_exp - op_s.eff_exp;

  assign s1_next.sig_l   = op_l.sig;
  assign s1_next.sig_s   = align_shift(op_s.sig, diff);
  assign s1_next.exp_max = op_l.eff_exp - BIAS_V;
  assign s1_next.sign    = op_l.sign;
  assign s1_next.eff_sub = sign_a ^ sign_b;

  logic    vld_p1, vld_p2;
  stage1_t pay_p1;
  logic    s2_load, accept;

  assign s2_load   = !vld_p2 || out_ready;
  assign in_ready  = !vld_p1 || s2_load;
  assign accept    = in_valid && in_ready;

  // ---- stage 1: ordered, aligned operands ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1 <= 1'b0;
      pay_p1 <= '0;
    end else if (in_ready) begin
      vld_p1 <= in_valid;
      if (accept)
        pay_p1 <= s1_next;
    end
  end

  logic [SIG_W:0] frac_next;
  logic           sign_next;

  // Subtraction cannot go negative because stage 1 put the larger magnitude in sig_l.
  assign frac_next = pay_p1.eff_sub ? ({1'b0, pay_p1.sig_l} - {1'b0, pay_p1.sig_s})
                                    : ({1'b0, pay_p1.sig_l} + {1'b0, pay_p1.sig_s});
  assign sign_next = pay_p1.sign && !(pay_p1.eff_sub && (frac_next == '0));

  // ---- stage 2: magnitude sum/difference ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p2          <= 1'b0;
      out_sign        <= 1'b0;
      out_exp_max     <= '0;
      out_fraction_25 <= '0;
      out_eff_sub     <= 1'b0;
    end else if (s2_load) begin
      vld_p2 <= vld_p1;
      if (vld_p1) begin
        out_sign        <= sign_next;
        out_exp_max     <= pay_p1.exp_max;
        out_fraction_25 <= frac_next;
        out_eff_sub     <= pay_p1.eff_sub;
      end
    end
  end

  assign out_valid = vld_p2;

endmodule

// File: tb/tb_fp_align_add.sv
// Directed scoreboard bench for fp_align_add; expected results are queued on
// input transfer and compared on output transfer.
module tb_fp_align_add;

  logic        clk = 1'b0;
  logic        rst_n, in_valid, in_ready, out_valid, out_ready;
  logic        out_sign, out_eff_sub;
  logic [31:0] in_a, in_b;
  logic [7:0]  out_exp_max;
  logic [24:0] out_fraction_25;
`ifdef FP_ALIGN_ADD_SUB_OP_EN
  logic        op_sub;
`endif

  always #5 clk = ~clk;

  fp_align_add dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
`ifdef FP_ALIGN_ADD_SUB_OP_EN
    .op_sub(op_sub),
`endif
    .in_a(in_a), .in_b(in_b), .out_valid(out_valid), .out_ready(out_ready),
    .out_sign(out_sign), .out_exp_max(out_exp_max),
    .out_fraction_25(out_fraction_25), .out_eff_sub(out_eff_sub)
  );

  typedef struct packed {
    logic        sign;
    logic [7:0]  exp_max;
    logic [24:0] frac;
    logic        eff_sub;
  } res_t;

  res_t        q[$];
  string       tq[$];
  res_t        exp_cur;
  string       tag_cur;
  logic        last_acc;
  int          checks = 0;
  int          errors = 0;
  logic [31:0] ta[7];
  logic [31:0] tb_v[7];
  res_t        te[7];

  task automatic check(input string tag, input logic [39:0] got, input logic [39:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s got=%h want=%h", tag, got, want);
    end
  endtask

  function automatic logic [39:0] outs();
    res_t r;
    r = {out_sign, out_exp_max, out_fraction_25, out_eff_sub};
    return 40'(r);
  endfunction

  task automatic drive_raw(input logic [31:0] a, input logic [31:0] b,
                           input res_t e, input string tag);
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    exp_cur  = e;
    tag_cur  = tag;
  endtask

  task automatic drive(input int i);
    drive_raw(ta[i], tb_v[i], te[i], $sformatf("vec%0d", i));
  endtask

  // Called just after a clock edge with inputs driven; advances one cycle.
  task automatic cycle();
    res_t  r;
    string t;
    #1;
    last_acc = in_valid && in_ready;
    if (last_acc) begin
      q.push_back(exp_cur);
      tq.push_back(tag_cur);
    end
    if (out_valid && out_ready) begin
      check("scoreboard_nonempty", 40'(q.size() != 0), 40'(1));
      if (q.size() != 0) begin
        r = q.pop_front();
        t = tq.pop_front();
        check(t, outs(), 40'(r));
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int budget);
    for (int c = 0; c < budget && q.size() > 0; c++)
      cycle();
    check("drain_empty", 40'(q.size()), 40'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int idx;
    ta[0] = 32'h3F800000; tb_v[0] = 32'h3F800000; te[0] = '{1'b0, 8'h00, 25'h1000000, 1'b0};
    ta[1] = 32'h3FC00000; tb_v[1] = 32'h3E800000; te[1] = '{1'b0, 8'h00, 25'h0E00000, 1'b0};
    ta[2] = 32'h40000000; tb_v[2] = 32'hC0400000; te[2] = '{1'b1, 8'h01, 25'h0400000, 1'b1};
    ta[3] = 32'h3F800000; tb_v[3] = 32'hBF800000; te[3] = '{1'b0, 8'h00, 25'h0000000, 1'b1};
    ta[4] = 32'h4B800000; tb_v[4] = 32'h3F800000; te[4] = '{1'b0, 8'h18, 25'h0800000, 1'b0};
    ta[5] = 32'h00000001; tb_v[5] = 32'h00000003; te[5] = '{1'b0, 8'h82, 25'h0000004, 1'b0};
    ta[6] = 32'h4B000000; tb_v[6] = 32'h3F800000; te[6] = '{1'b0, 8'h17, 25'h0800001, 1'b0};

    rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b1;
`ifdef FP_ALIGN_ADD_SUB_OP_EN
    op_sub = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 40'(out_valid), 40'(0));
    check("rst_outputs", outs(), 40'(0));
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("ready_after_reset", 40'(in_ready), 40'(1));

    // Latency of the first operation.
    drive(0);
    cycle();
    in_valid = 1'b0;
    check("latency_not_early", 40'(out_valid), 40'(0));
    cycle();
    check("latency_2", 40'(out_valid), 40'(1));
    drain(10);

    // Back-to-back stream, every vector, full throughput.
    for (int i = 0; i < 7; i++) begin
      drive(i);
      cycle();
      check("throughput_accept", 40'(last_acc), 40'(1));
    end
    in_valid = 1'b0;
    drain(20);

    // Backpressure: four pairs offered with out_ready low for five cycles.
    out_ready = 1'b0;
    idx = 0;
    for (int c = 0; c < 5; c++) begin
      drive(idx);
      cycle();
      if (last_acc) idx++;
      if (out_valid && q.size() > 0)
        check("hold_stable", outs(), 40'(q[0]));
    end
    check("bp_accepted", 40'(idx), 40'(2));
    check("bp_in_ready_low", 40'(in_ready), 40'(0));
    out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      if (idx < 4) drive(idx);
      else in_valid = 1'b0;
      check("bp_stream_valid", 40'(out_valid), 40'(1));
      cycle();
      if (last_acc) idx++;
    end
    in_valid = 1'b0;
    check("bp_all_accepted", 40'(idx), 40'(4));
    check("bp_all_delivered", 40'(q.size()), 40'(0));

    // Reset with both stages occupied.
    out_ready = 1'b0;
    drive(4);
    cycle();
    drive(5);
    cycle();
    in_valid = 1'b0;
    check("mid_pre_full", 40'({out_valid, in_ready}), 40'(2'b10));
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 40'(out_valid), 40'(0));
    check("mid_rst_outputs", outs(), 40'(0));
    q.delete();
    tq.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      check("no_stale", 40'(out_valid), 40'(0));
      cycle();
    end

`ifdef FP_ALIGN_ADD_SUB_OP_EN
    op_sub = 1'b1;
    drive_raw(32'h40400000, 32'h40000000, '{1'b0, 8'h01, 25'h0400000, 1'b1}, "op_sub");
    cycle();
    in_valid = 1'b0;
    op_sub = 1'b0;
    drain(10);
`endif

    drive(2);
    cycle();
    in_valid = 1'b0;
    drain(10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
